mips_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the MIPS core: fetches an instruction word, decodes it, drives the registered ALU's opcode/funct/shamt and operand-select controls, runs data-memory handshakes for loads/stores, and issues register-file write-back and PC-increment strobes. It sits between instruction memory, the register file, the ALU and data memory, and is the only block that advances architectural state.

---
 rtl/mips_ctrl_pkg.sv | 45 ++++
 rtl/mips_ctrl_fsm_decoder.sv | 65 ++++++
 rtl/mips_ctrl_fsm.sv | 152 +++++++++++++++
 tb/tb_mips_ctrl_fsm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS control sequencer: FSM state codes, opcode/funct
// values (common with the ALU) and write-back source selects.
package mips_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_ONE = 2'd2;

endpackage

// File: rtl/mips_ctrl_fsm_decoder.sv
// Combinational instruction classifier: opcode/funct -> legality and class flags.
module mips_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       legal,
    output logic       is_load,
    output logic       is_store,
    output logic       is_sc,
    output logic       is_rtype,
    output logic       zero_ext,
    output logic       writes_reg
);

    always_comb begin
        legal      = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_sc      = 1'b0;
        is_rtype   = 1'b0;
        zero_ext   = 1'b0;
        writes_reg = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                is_rtype = 1'b1;
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: begin
                        legal      = 1'b1;
                        writes_reg = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                legal      = 1'b1;
                writes_reg = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                legal      = 1'b1;
                writes_reg = 1'b1;
                zero_ext   = 1'b1;
            end
            OP_LW, OP_LBU, OP_LHU, OP_LL: begin
                legal      = 1'b1;
                writes_reg = 1'b1;
                is_load    = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                legal    = 1'b1;
                is_store = 1'b1;
            end
            // sc stores and then writes its success flag (constant 1) back
            OP_SC: begin
                legal      = 1'b1;
                is_store   = 1'b1;
                is_sc      = 1'b1;
                writes_reg = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: fetch, decode, execute, memory, write-back.
// Every output is decoded from the state and IR flops only, never from ack inputs.
module mips_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [4:0]  rf_rs,
    output logic [4:0]  rf_rt,
    output logic [4:0]  rf_wa,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_funct,
    output logic [4:0]  alu_shamt,
    output logic        alu_src_imm,
    output logic [31:0] imm_ext,
    output logic        pc_inc,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] retired,
    output logic [2:0]  state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [31:0]   ir_q, ir_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          illegal_q, illegal_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   retired_q, retired_d;

    logic legal, is_load, is_store, is_sc, is_rtype, zero_ext, writes_reg;

    mips_decoder u_dec (
        .opcode     (ir_q[31:26]),
        .funct      (ir_q[5:0]),
        .legal      (legal),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_sc      (is_sc),
        .is_rtype   (is_rtype),
        .zero_ext   (zero_ext),
        .writes_reg (writes_reg)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: if (run) begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_FETCH: begin
                // an ack in the final wait cycle still wins over the timeout
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_WB;
                end
            end
            S_EXEC: begin
                state_d = (is_load || is_store) ? S_MEM : S_WB;
                wait_d  = '0;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                retired_d = retired_q + 32'd1;
                state_d   = run ? S_FETCH : S_IDLE;
                wait_d    = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        imem_req    = (state_q == S_FETCH);
        dmem_req    = (state_q == S_MEM);
        dmem_we     = dmem_req && is_store;
        rf_rs       = ir_q[25:21];
        rf_rt       = ir_q[20:16];
        rf_wa       = is_rtype ? ir_q[15:11] : ir_q[20:16];
        rf_we       = (state_q == S_WB) && writes_reg && (rf_wa != 5'd0);
        wb_sel      = is_load ? WB_MEM : (is_sc ? WB_ONE : WB_ALU);
        alu_opcode  = ir_q[31:26];
        alu_funct   = ir_q[5:0];
        alu_shamt   = ir_q[10:6];
        alu_src_imm = !is_rtype;
        imm_ext     = zero_ext ? {16'h0000, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
        pc_inc      = (state_q == S_WB);
        illegal     = illegal_q;
        bus_err     = bus_err_q;
        retired     = retired_q;
        state       = state_q;
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm: table of instructions walked through every
// pipeline stage, plus hand sequences for ack timing, timeout and async reset.
module tb_mips_ctrl_fsm;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n, run, imem_ack, dmem_ack;
    logic [31:0] imem_data;
    logic        imem_req, dmem_req, dmem_we, rf_we, alu_src_imm, pc_inc, illegal, bus_err;
    logic [4:0]  rf_rs, rf_rt, rf_wa, alu_shamt;
    logic [1:0]  wb_sel;
    logic [5:0]  alu_opcode, alu_funct;
    logic [31:0] imm_ext, retired;
    logic [2:0]  state;

    int n_chk = 0;
    int n_fail = 0;
    logic exp_ill = 1'b0;

    always #5 clk = ~clk;

    mips_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_wa(rf_wa), .rf_we(rf_we), .wb_sel(wb_sel),
        .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_shamt(alu_shamt),
        .alu_src_imm(alu_src_imm), .imm_ext(imm_ext), .pc_inc(pc_inc),
        .illegal(illegal), .bus_err(bus_err), .retired(retired), .state(state)
    );

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs, rt, wa, shamt;
        logic        we;
        logic [1:0]  sel;
        logic        src_imm;
        logic [31:0] imm;
        logic        mem, store;
        int          dly;
        logic        bad;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(logic [31:0] instr, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] wa, logic [4:0] shamt, logic we, logic [1:0] sel,
                                logic src_imm, logic [31:0] imm, logic mem, logic store,
                                int dly, logic bad);
        vec_t v;
        v.instr = instr; v.rs = rs; v.rt = rt; v.wa = wa; v.shamt = shamt; v.we = we;
        v.sel = sel; v.src_imm = src_imm; v.imm = imm; v.mem = mem; v.store = store;
        v.dly = dly; v.bad = bad;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge after WB.
    task automatic run_vec(input vec_t v, input int idly, input logic [31:0] exp_ret,
                           input logic [2:0] exp_next);
        for (int i = 0; i < idly; i++) begin
            check("fetch wait state", state, ST_FETCH);
            check("fetch wait imem_req", imem_req, 1);
            step();
        end
        check("fetch state", state, ST_FETCH);
        check("fetch imem_req", imem_req, 1);
        imem_ack = 1'b1;
        imem_data = v.instr;
        step();
        imem_ack = 1'b0;
        imem_data = 32'hDEAD_BEEF;
        check("decode state", state, ST_DECODE);
        check("decode rf_rs", rf_rs, v.rs);
        check("decode rf_rt", rf_rt, v.rt);
        check("decode imem_req", imem_req, 0);
        check("decode pc_inc", pc_inc, 0);
        if (!v.bad) begin
            step();
            check("exec state", state, ST_EXEC);
            check("exec alu_src_imm", alu_src_imm, v.src_imm);
            check("exec imm_ext", imm_ext, v.imm);
            check("exec alu_opcode", alu_opcode, v.instr[31:26]);
            check("exec alu_shamt", alu_shamt, v.shamt);
            check("exec rf_we", rf_we, 0);
            if (v.mem) begin
                for (int i = 0; i <= v.dly; i++) begin
                    step();
                    check("mem state", state, ST_MEM);
                    check("mem dmem_req", dmem_req, 1);
                    check("mem dmem_we", dmem_we, v.store);
                    check("mem rf_we", rf_we, 0);
                    if (i == v.dly) dmem_ack = 1'b1;
                end
            end
        end
        step();
        dmem_ack = 1'b0;
        if (v.bad) exp_ill = 1'b1;
        check("wb state", state, ST_WB);
        check("wb rf_we", rf_we, v.we);
        check("wb rf_wa", rf_wa, v.wa);
        if (v.we) check("wb wb_sel", wb_sel, v.sel);
        check("wb pc_inc", pc_inc, 1);
        check("wb dmem_req", dmem_req, 0);
        check("wb illegal", illegal, exp_ill);
        check("wb bus_err", bus_err, 0);
        step();
        check("post-wb retired", retired, exp_ret);
        check("post-wb rf_we", rf_we, 0);
        check("post-wb pc_inc", pc_inc, 0);
        check("post-wb state", state, exp_next);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(32'h0022_1820, 1, 2, 3, 0,  1, 0, 0, 32'h0000_1820, 0, 0, 0, 0); // add $3,$1,$2
        tbl[1]  = mk(32'h3405_8000, 0, 5, 5, 0,  1, 0, 1, 32'h0000_8000, 0, 0, 0, 0); // ori
        tbl[2]  = mk(32'h2026_8000, 1, 6, 6, 0,  1, 0, 1, 32'hFFFF_8000, 0, 0, 0, 0); // addi
        tbl[3]  = mk(32'hAC47_0004, 2, 7, 7, 0,  0, 0, 1, 32'h0000_0004, 1, 1, 3, 0); // sw, ack +3
        tbl[4]  = mk(32'h8C28_0000, 1, 8, 8, 0,  1, 1, 1, 32'h0000_0000, 1, 0, 0, 0); // lw
        tbl[5]  = mk(32'hE029_0000, 1, 9, 9, 0,  1, 2, 1, 32'h0000_0000, 1, 1, 1, 0); // sc
        tbl[6]  = mk(32'h0001_0020, 0, 1, 0, 0,  0, 0, 0, 32'h0000_0020, 0, 0, 0, 0); // add to $0
        tbl[7]  = mk(32'h0002_1080, 0, 2, 2, 2,  1, 0, 0, 32'h0000_1080, 0, 0, 0, 0); // sll $2,$2,2
        tbl[8]  = mk(32'h3084_FFFF, 4, 4, 4, 31, 1, 0, 1, 32'h0000_FFFF, 0, 0, 0, 0); // andi
        tbl[9]  = mk(32'h0000_003F, 0, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 0, 0, 0, 1); // bad funct
        tbl[10] = mk(32'hFC00_0000, 0, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 0, 0, 0, 1); // opcode 3F

        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_data = 32'h0;
        step();
        step();
        check("reset state", state, ST_IDLE);
        check("reset imem_req", imem_req, 0);
        check("reset dmem_req", dmem_req, 0);
        check("reset rf_we", rf_we, 0);
        check("reset pc_inc", pc_inc, 0);
        check("reset retired", retired, 0);
        check("reset flags", {illegal, bus_err}, 0);
        check("reset imm_ext", imm_ext, 0);
        check("reset rf_rs", rf_rs, 0);
        rst_n = 1'b1;

        // Ack while idle must not load the IR.
        imem_ack = 1'b1;
        imem_data = 32'h0022_1820;
        step();
        check("idle ack state", state, ST_IDLE);
        check("idle ack rf_rs", rf_rs, 0);
        imem_ack = 1'b0;
        run = 1'b1;
        step();

        for (int i = 0; i < 11; i++) run_vec(tbl[i], 0, 32'(i + 1), ST_FETCH);

        // Ack in the last permitted fetch cycle wins over the timeout.
        run_vec(tbl[0], 3, 32'd12, ST_FETCH);

        // Fetch timeout: four cycles of request, then IDLE with bus_err.
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("timeout wait state", state, ST_FETCH);
            check("timeout imem_req", imem_req, 1);
            check("timeout bus_err low", bus_err, 0);
            step();
        end
        check("timeout state", state, ST_IDLE);
        check("timeout bus_err", bus_err, 1);
        check("timeout imem_req drop", imem_req, 0);
        check("timeout pc_inc", pc_inc, 0);
        check("timeout retired", retired, 12);
        step();
        check("timeout stays idle", state, ST_IDLE);

        // Reset in the middle of a load's memory phase.
        run = 1'b1;
        step();
        check("rst seq fetch", state, ST_FETCH);
        imem_ack = 1'b1;
        imem_data = 32'h8C28_0000;
        step();
        imem_ack = 1'b0;
        step();
        step();
        check("rst seq mem state", state, ST_MEM);
        check("rst seq dmem_req", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst dmem_req", dmem_req, 0);
        check("async rst state", state, ST_IDLE);
        check("async rst rf_we", rf_we, 0);
        check("async rst retired", retired, 0);
        check("async rst flags", {illegal, bus_err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
